// File: rtl/emmc_dat_rx.sv
// Single-lane eMMC/SD read-data block receiver.
// Deserialises one block MSB-first, checks CRC-16 and the end bit.
module emmc_dat_rx #(
  parameter int BLOCK_BYTES  = 512,
  parameter int TIMEOUT_BITS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        bit_en,
  input  logic        dat,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        busy,
  output logic        done,
  output logic        crc_err,
  output logic        end_err,
  output logic        timeout,
  output logic [15:0] crc_calc,
  output logic [15:0] crc_rx
);

  localparam int BW = $clog2(BLOCK_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_BITS + 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(BLOCK_BYTES);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_CRC,
    S_END
  } state_t;

  state_t state_q, state_d;

  logic [7:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [BW-1:0] byte_cnt;
  logic [TW-1:0] to_cnt;

  logic [BW-1:0] byte_nxt;
  logic [TW-1:0] to_nxt;
  logic          inv;
  logic [15:0]   crc_nxt;

  logic arm, to_inc, to_hit;
  logic shift_data, byte_end;
  logic shift_crc, fin;

  assign byte_nxt = byte_cnt + BW'(1);
  assign to_nxt   = to_cnt + TW'(1);
  assign busy     = (state_q != S_IDLE);

  // Serial CRC-16 (x^16+x^12+x^5+1), one data bit per strobe
  assign inv     = dat ^ crc_calc[15];
  assign crc_nxt = {crc_calc[14:12], crc_calc[11] ^ inv,
                    crc_calc[10:5],  crc_calc[4] ^ inv,
                    crc_calc[3:0],   inv};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    arm        = 1'b0;
    to_inc     = 1'b0;
    to_hit     = 1'b0;
    shift_data = 1'b0;
    byte_end   = 1'b0;
    shift_crc  = 1'b0;
    fin        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          arm     = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bit_en) begin
          if (!dat) begin
            state_d = S_DATA;
          end else begin
            to_inc = 1'b1;
            if (to_nxt == TO_LAST) begin
              to_hit  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      S_DATA: begin
        if (bit_en) begin
          shift_data = 1'b1;
          if (bit_cnt == 4'd7) begin
            byte_end = 1'b1;
            if (byte_nxt == BYTE_LAST) state_d = S_CRC;
          end
        end
      end
      S_CRC: begin
        if (bit_en) begin
          shift_crc = 1'b1;
          if (bit_cnt == 4'd15) state_d = S_END;
        end
      end
      S_END: begin
        if (bit_en) begin
          fin     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d    = S_IDLE;
      arm        = 1'b0;
      to_inc     = 1'b0;
      to_hit     = 1'b0;
      shift_data = 1'b0;
      byte_end   = 1'b0;
      shift_crc  = 1'b0;
      fin        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      to_cnt     <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      done       <= 1'b0;
      crc_err    <= 1'b0;
      end_err    <= 1'b0;
      timeout    <= 1'b0;
      crc_calc   <= '0;
      crc_rx     <= '0;
    end else begin
      byte_valid <= byte_end;
      done       <= to_hit | fin;
      if (arm) begin
        crc_err  <= 1'b0;
        end_err  <= 1'b0;
        timeout  <= 1'b0;
        crc_calc <= '0;
        crc_rx   <= '0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        to_cnt   <= '0;
      end
      if (to_inc) to_cnt <= to_nxt;
      if (to_hit) timeout <= 1'b1;
      if (shift_data) begin
        shreg    <= {shreg[6:0], dat};
        crc_calc <= crc_nxt;
        bit_cnt  <= byte_end ? 4'd0 : bit_cnt + 4'd1;
      end
      if (byte_end) begin
        byte_data <= {shreg[6:0], dat};
        byte_cnt  <= byte_nxt;
      end
      // 4-bit counter wraps to 0 after the 16th CRC bit
      if (shift_crc) begin
        crc_rx  <= {crc_rx[14:0], dat};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (fin) begin
        end_err <= ~dat;
        crc_err <= (crc_rx != crc_calc);
      end
    end
  end

endmodule

// File: tb/tb_emmc_dat_rx.sv
// Scoreboard bench for emmc_dat_rx: three instances
// (default, one-byte block, short timeout) share the DAT line.
module tb_emmc_dat_rx;

  typedef struct packed {
    logic        ce;
    logic        ee;
    logic        tm;
    logic [15:0] calc;
    logic [15:0] rx;
  } done_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] st;
  logic       abort, bit_en, dat;

  logic [7:0]  bd[3];
  logic        bv[3], bsy[3], dn[3], ce[3], ee[3], tm[3];
  logic [15:0] calc[3], rx[3];

  logic [7:0] bq0[$], bq1[$];
  done_t      dq0[$], dq1[$], dq2[$];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  emmc_dat_rx u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .abort(abort),
    .bit_en(bit_en), .dat(dat), .byte_data(bd[0]),
    .byte_valid(bv[0]), .busy(bsy[0]), .done(dn[0]),
    .crc_err(ce[0]), .end_err(ee[0]), .timeout(tm[0]),
    .crc_calc(calc[0]), .crc_rx(rx[0])
  );

  emmc_dat_rx #(.BLOCK_BYTES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .abort(abort),
    .bit_en(bit_en), .dat(dat), .byte_data(bd[1]),
    .byte_valid(bv[1]), .busy(bsy[1]), .done(dn[1]),
    .crc_err(ce[1]), .end_err(ee[1]), .timeout(tm[1]),
    .crc_calc(calc[1]), .crc_rx(rx[1])
  );

  emmc_dat_rx #(.TIMEOUT_BITS(16)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .abort(abort),
    .bit_en(bit_en), .dat(dat), .byte_data(bd[2]),
    .byte_valid(bv[2]), .busy(bsy[2]), .done(dn[2]),
    .crc_err(ce[2]), .end_err(ee[2]), .timeout(tm[2]),
    .crc_calc(calc[2]), .crc_rx(rx[2])
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic unexp(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected pulse, expected none", nm);
  endtask

  task automatic chk_done(string nm, done_t e, int i);
    chk({nm, "_crc_err"}, 64'(ce[i]), 64'(e.ce));
    chk({nm, "_end_err"}, 64'(ee[i]), 64'(e.ee));
    chk({nm, "_timeout"}, 64'(tm[i]), 64'(e.tm));
    chk({nm, "_crc_calc"}, 64'(calc[i]), 64'(e.calc));
    chk({nm, "_crc_rx"}, 64'(rx[i]), 64'(e.rx));
    chk({nm, "_busy"}, 64'(bsy[i]), 64'd0);
  endtask

  // Monitors
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bv[0]) begin
        if (bq0.size() == 0) unexp("byte0");
        else chk("byte0", 64'(bd[0]), 64'(bq0.pop_front()));
      end
      if (dn[0]) begin
        if (dq0.size() == 0) unexp("done0");
        else chk_done("done0", dq0.pop_front(), 0);
      end
      if (bv[1]) begin
        if (bq1.size() == 0) unexp("byte1");
        else chk("byte1", 64'(bd[1]), 64'(bq1.pop_front()));
      end
      if (dn[1]) begin
        if (dq1.size() == 0) unexp("done1");
        else chk_done("done1", dq1.pop_front(), 1);
      end
      if (bv[2]) unexp("byte2");
      if (dn[2]) begin
        if (dq2.size() == 0) unexp("done2");
        else chk_done("done2", dq2.pop_front(), 2);
      end
    end
  end

  task automatic bit_t(logic b);
    @(posedge clk);
    #1 dat = b;
    bit_en = 1'b1;
    @(posedge clk);
    #1 bit_en = 1'b0;
  endtask

  task automatic pulse_start(int sel);
    @(posedge clk);
    #1 st[sel] = 1'b1;
    @(posedge clk);
    #1 st = '0;
  endtask

  task automatic send_bytes(int sel, int n, logic [7:0] v);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) bq0.push_back(v);
      else bq1.push_back(v);
      for (int j = 7; j >= 0; j--) bit_t(v[j]);
    end
  endtask

  task automatic send_tail(logic [15:0] c, logic endb);
    for (int j = 15; j >= 0; j--) bit_t(c[j]);
    bit_t(endb);
  endtask

  task automatic settle(string nm);
    repeat (4) @(posedge clk);
    #1;
    chk({nm, "_pend_b0"}, 64'(bq0.size()), 64'd0);
    chk({nm, "_pend_b1"}, 64'(bq1.size()), 64'd0);
    chk({nm, "_pend_d0"}, 64'(dq0.size()), 64'd0);
    chk({nm, "_pend_d1"}, 64'(dq1.size()), 64'd0);
    chk({nm, "_pend_d2"}, 64'(dq2.size()), 64'd0);
  endtask

  task automatic good_block(string nm);
    pulse_start(0);
    chk({nm, "_busy"}, 64'(bsy[0]), 64'd1);
    bit_t(1'b0);
    send_bytes(0, 512, 8'hFF);
    dq0.push_back('{1'b0, 1'b0, 1'b0, 16'h7FA1, 16'h7FA1});
    send_tail(16'h7FA1, 1'b1);
    settle(nm);
  endtask

  initial begin
    rst_n  = 1'b0;
    st     = '0;
    abort  = 1'b0;
    bit_en = 1'b0;
    dat    = 1'b1;
    #3;
    chk("rst_outs", {bd[0], bv[0], bsy[0], dn[0], ce[0], ee[0],
                     tm[0], calc[0], rx[0]}, 64'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // All-0xFF block, correct CRC
    good_block("ff_good");

    // Same block, CRC sent one off
    pulse_start(0);
    bit_t(1'b0);
    send_bytes(0, 512, 8'hFF);
    dq0.push_back('{1'b1, 1'b0, 1'b0, 16'h7FA1, 16'h7FA0});
    send_tail(16'h7FA0, 1'b1);
    settle("ff_bad");

    // One-byte block with a bad end bit
    pulse_start(1);
    chk("one_busy", 64'(bsy[1]), 64'd1);
    bit_t(1'b0);
    send_bytes(1, 1, 8'hA5);
    dq1.push_back('{1'b0, 1'b1, 1'b0, 16'hE54F, 16'hE54F});
    send_tail(16'hE54F, 1'b0);
    settle("one");

    // Start-bit timeout after 16 strobes
    pulse_start(2);
    repeat (15) bit_t(1'b1);
    chk("to_busy15", 64'(bsy[2]), 64'd1);
    dq2.push_back('{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000});
    bit_t(1'b1);
    settle("to");
    chk("to_busy_end", 64'(bsy[2]), 64'd0);

    // Abort mid-block
    pulse_start(0);
    bit_t(1'b0);
    send_bytes(0, 100, 8'hFF);
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", 64'(bsy[0]), 64'd0);
    @(posedge clk);
    #1 st[0] = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 st = '0;
    abort = 1'b0;
    chk("start_abort_busy", 64'(bsy[0]), 64'd0);
    settle("abort");
    good_block("after_abort");

    // Asynchronous reset mid-DATA
    pulse_start(0);
    bit_t(1'b0);
    send_bytes(0, 50, 8'hFF);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {bd[0], bv[0], bsy[0], dn[0], ce[0], ee[0],
                         tm[0], calc[0], rx[0]}, 64'd0);
    bq0.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Good block with a START issued while busy
    pulse_start(0);
    chk("rst_busy", 64'(bsy[0]), 64'd1);
    bit_t(1'b0);
    send_bytes(0, 10, 8'hFF);
    pulse_start(0);
    send_bytes(0, 502, 8'hFF);
    dq0.push_back('{1'b0, 1'b0, 1'b0, 16'h7FA1, 16'h7FA1});
    send_tail(16'h7FA1, 1'b1);
    settle("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
